// File: rtl/uop_pkg.sv
// Shared definitions for the uop sequencer: queue depth, instruction field
// positions within a uop, and the sequencer state encoding.
package uop_pkg;

  localparam int UOP_Q_DEPTH = 4;
  localparam int UOP_Q_CW    = $clog2(UOP_Q_DEPTH + 1);
  localparam int INSN1_LSB   = 0;
  localparam int INSN2_LSB   = 32;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_RUN
  } seq_state_e;

endpackage

// File: rtl/uop_queue.sv
// Small synchronous FIFO of {pc, uop} pairs between the uop buffer read
// pipeline and the downstream consumer. Flush empties it in one edge.
module uop_queue
  import uop_pkg::*;
#(
  parameter int AW = 7,
  parameter int DW = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                push,
  input  logic [AW-1:0]       push_pc,
  input  logic [DW-1:0]       push_uop,
  input  logic                pop,
  output logic [UOP_Q_CW-1:0] count,
  output logic [AW-1:0]       head_pc,
  output logic [DW-1:0]       head_uop
);

  localparam int PW = $clog2(UOP_Q_DEPTH);

  logic [AW-1:0]       r_pc  [UOP_Q_DEPTH];
  logic [DW-1:0]       r_uop [UOP_Q_DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [UOP_Q_CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + UOP_Q_CW'(push) - UOP_Q_CW'(pop);
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      r_pc[r_wr_ptr]  <= push_pc;
      r_uop[r_wr_ptr] <= push_uop;
    end
  end

  assign count    = r_count;
  assign head_pc  = r_pc[r_rd_ptr];
  assign head_uop = r_uop[r_rd_ptr];

endmodule

// File: rtl/uop_sequencer.sv
// Walks a bounded run of uop buffer addresses, tracks the 1-cycle read,
// queues returning uops and hands them downstream as 32-bit instruction pairs.
module uop_sequencer
  import uop_pkg::*;
#(
  parameter int  UOP_BUF_SIZE  = 128,
  parameter int  UOP_BUF_WIDTH = 64,
  parameter int  RESET_ADDR    = 0,
  localparam int AW            = $clog2(UOP_BUF_SIZE)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [AW-1:0]            start_addr,
  input  logic [AW:0]              start_len,
  input  logic                     redirect,
  input  logic [AW-1:0]            redirect_addr,
  input  logic [AW:0]              redirect_len,
  output logic [AW-1:0]            uop_addr,
  input  logic [UOP_BUF_WIDTH-1:0] uop,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              instruction_1,
  output logic [31:0]              instruction_2,
  output logic [AW-1:0]            out_pc,
  output logic                     busy,
  output logic                     done
);

  localparam int UW = UOP_Q_CW + 1;

  seq_state_e r_state;
  seq_state_e w_state_nxt;

  logic [AW-1:0]            r_uop_addr;
  logic [AW-1:0]            r_next_addr;
  logic [AW:0]              r_remaining;
  logic                     r_vld_p0;
  logic                     r_vld_p1;
  logic [AW-1:0]            r_pc_p1;
  logic [UOP_Q_CW-1:0]      w_count;
  logic [AW-1:0]            w_head_pc;
  logic [UOP_BUF_WIDTH-1:0] w_head_uop;
  logic [UW-1:0]            w_used;
  logic                     w_pop;
  logic                     w_issue;
  logic                     w_start_go;
  logic                     w_start_issue;
  logic                     w_drained;
  logic                     w_done;

  assign out_valid = (w_count != '0);
  assign w_pop     = out_valid && out_ready;

  // Slots committed after this edge: queue survivors plus reads still in flight.
  assign w_used = UW'(w_count) - UW'(w_pop) + UW'(r_vld_p0) + UW'(r_vld_p1);

  assign w_start_go    = (r_state == SEQ_IDLE) && start && !redirect;
  assign w_start_issue = w_start_go && (start_len != '0);
  assign w_issue       = (r_state == SEQ_RUN) && (r_remaining != '0) &&
                         (w_used < UW'(UOP_Q_DEPTH)) && !redirect;
  assign w_drained     = (r_remaining == '0) && (w_used == '0);

  always_ff @(posedge clk) begin
    if (reset) r_state <= SEQ_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      SEQ_IDLE: if (start) w_state_nxt = SEQ_RUN;
      SEQ_RUN: begin
        if (w_drained) begin
          w_state_nxt = SEQ_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = SEQ_IDLE;
    endcase
    if (redirect) begin
      w_state_nxt = SEQ_RUN;
      w_done      = 1'b0;
    end
  end

  // p0: address presented to the uop buffer this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_uop_addr  <= AW'(RESET_ADDR);
      r_next_addr <= AW'(RESET_ADDR);
      r_remaining <= '0;
      r_vld_p0    <= 1'b0;
      r_vld_p1    <= 1'b0;
    end else if (redirect) begin
      r_next_addr <= redirect_addr;
      r_remaining <= redirect_len;
      r_vld_p0    <= 1'b0;
      r_vld_p1    <= 1'b0;
    end else begin
      r_vld_p0 <= w_start_issue || w_issue;
      r_vld_p1 <= r_vld_p0;
      if (w_start_issue) begin
        r_uop_addr  <= start_addr;
        r_next_addr <= start_addr + AW'(1);
        r_remaining <= start_len - (AW + 1)'(1);
      end else if (w_start_go) begin
        r_next_addr <= start_addr;
        r_remaining <= '0;
      end else if (w_issue) begin
        r_uop_addr  <= r_next_addr;
        r_next_addr <= r_next_addr + AW'(1);
        r_remaining <= r_remaining - (AW + 1)'(1);
      end
    end
  end

  // p1: read data for this address is on uop; pushed into the queue next edge.
  always_ff @(posedge clk) begin
    r_pc_p1 <= r_uop_addr;
  end

  uop_queue #(
    .AW(AW),
    .DW(UOP_BUF_WIDTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect),
    .push     (r_vld_p1),
    .push_pc  (r_pc_p1),
    .push_uop (uop),
    .pop      (w_pop),
    .count    (w_count),
    .head_pc  (w_head_pc),
    .head_uop (w_head_uop)
  );

  assign uop_addr      = r_uop_addr;
  assign instruction_1 = out_valid ? w_head_uop[INSN1_LSB +: 32] : '0;
  assign instruction_2 = out_valid ? w_head_uop[INSN2_LSB +: 32] : '0;
  assign out_pc        = out_valid ? w_head_pc : '0;
  assign busy          = (r_state == SEQ_RUN);
  assign done          = w_done && !reset;

endmodule

// File: tb/tb_uop_sequencer.sv
// Directed bench for uop_sequencer with a synchronous uop buffer model and a
// scoreboard of expected pcs popped by an independent output monitor.
module tb_uop_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [6:0]  start_addr;
  logic [7:0]  start_len;
  logic        redirect;
  logic [6:0]  redirect_addr;
  logic [7:0]  redirect_len;
  logic [6:0]  uop_addr;
  logic [63:0] uop;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction_1;
  logic [31:0] instruction_2;
  logic [6:0]  out_pc;
  logic        busy;
  logic        done;

  int total;
  int bad;
  int done_cnt;
  int d0;
  logic [6:0] a0;
  logic [6:0] exp_q[$];

  uop_sequencer #(
    .UOP_BUF_SIZE (128),
    .UOP_BUF_WIDTH(64),
    .RESET_ADDR   (0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .start_addr   (start_addr),
    .start_len    (start_len),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .redirect_len (redirect_len),
    .uop_addr     (uop_addr),
    .uop          (uop),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .instruction_1(instruction_1),
    .instruction_2(instruction_2),
    .out_pc       (out_pc),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] word(input logic [6:0] a);
    return {32'hC0DE_0000 | {25'd0, a}, 32'h1234_0000 | {25'd0, a}};
  endfunction

  initial uop = '0;
  always @(posedge clk) uop <= word(uop_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  // Output monitor: every accepted pair must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (done === 1'b1) done_cnt++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 64'(out_pc), 64'h7F_DEAD);
        end else begin
          logic [6:0] pc;
          logic [63:0] w;
          pc = exp_q.pop_front();
          w  = word(pc);
          chk("mon_pc", 64'(out_pc), 64'(pc));
          chk("mon_insn1", 64'(instruction_1), 64'(w[31:0]));
          chk("mon_insn2", 64'(instruction_2), 64'(w[63:32]));
        end
      end
    end
  end

  initial begin
    total = 0; bad = 0; done_cnt = 0;
    reset = 1'b1; start = 1'b0; start_addr = '0; start_len = '0;
    redirect = 1'b0; redirect_addr = '0; redirect_len = '0; out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_addr", 64'(uop_addr), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_insn", {instruction_2, instruction_1}, 64'd0);
    reset = 1'b0;
    tick();

    // Basic run 5..8 at full throughput.
    d0 = done_cnt;
    for (int i = 5; i <= 8; i++) exp_q.push_back(7'(i));
    start_addr = 7'd5; start_len = 8'd4; start = 1'b1;
    tick();
    chk("t1_addr", 64'(uop_addr), 64'd5);
    chk("t1_busy", 64'(busy), 64'd1);
    start = 1'b0;
    tick();
    chk("t1_novalid", 64'(out_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_first_pc", 64'(out_pc), 64'd5);
    wait_done(10);
    chk("t1_done_pc", 64'(out_pc), 64'd8);
    tick();
    chk("t1_busy_fall", 64'(busy), 64'd0);
    chk("t1_done_cnt", 64'(done_cnt), 64'(d0 + 1));

    // Address wrap 126 -> 1.
    for (int i = 0; i < 4; i++) exp_q.push_back(7'(126 + i));
    start_addr = 7'd126; start_len = 8'd4; start = 1'b1;
    tick();
    chk("t2_addr0", 64'(uop_addr), 64'd126);
    start = 1'b0;
    tick();
    chk("t2_addr1", 64'(uop_addr), 64'd127);
    tick();
    chk("t2_addr2", 64'(uop_addr), 64'd0);
    chk("t2_pc126", 64'(out_pc), 64'd126);
    tick();
    chk("t2_addr3", 64'(uop_addr), 64'd1);
    chk("t2_pc127", 64'(out_pc), 64'd127);
    chk("t2_insn1", 64'(instruction_1), 64'h1234_007F);
    chk("t2_insn2", 64'(instruction_2), 64'hC0DE_007F);
    wait_done(10);
    tick();
    chk("t2_idle", 64'(busy), 64'd0);

    // Backpressure: 10 uops, consumer stalled for 6 cycles after first valid.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) exp_q.push_back(7'(i));
    start_addr = 7'd0; start_len = 8'd10; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("t3_valid", 64'(out_valid), 64'd1);
    chk("t3_head0", 64'(out_pc), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_addr_hold", 64'(uop_addr), 64'd3);
      chk("t3_head_hold", 64'(out_pc), 64'd0);
    end
    out_ready = 1'b1;
    wait_done(30);
    tick();
    chk("t3_idle", 64'(busy), 64'd0);
    chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // Redirect while three stale entries are queued.
    out_ready = 1'b0;
    start_addr = 7'd20; start_len = 8'd8; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("t4_stale_head", 64'(out_pc), 64'd20);
    d0 = done_cnt;
    exp_q.push_back(7'd40);
    exp_q.push_back(7'd41);
    redirect = 1'b1; redirect_addr = 7'd40; redirect_len = 8'd2;
    tick();
    redirect = 1'b0;
    chk("t4_flushed", 64'(out_valid), 64'd0);
    chk("t4_busy", 64'(busy), 64'd1);
    out_ready = 1'b1;
    wait_done(20);
    chk("t4_done_pc", 64'(out_pc), 64'd41);
    tick();
    chk("t4_idle", 64'(busy), 64'd0);
    chk("t4_done_cnt", 64'(done_cnt), 64'(d0 + 1));

    // Zero-length run.
    a0 = uop_addr;
    d0 = done_cnt;
    start_addr = 7'd77; start_len = 8'd0; start = 1'b1;
    tick();
    chk("t5_busy", 64'(busy), 64'd1);
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_addr", 64'(uop_addr), 64'(a0));
    start = 1'b0;
    tick();
    chk("t5_idle", 64'(busy), 64'd0);
    chk("t5_novalid", 64'(out_valid), 64'd0);
    chk("t5_done_cnt", 64'(done_cnt), 64'(d0 + 1));
    chk("t5_addr_hold", 64'(uop_addr), 64'(a0));

    // Reset mid-run with start held high.
    start_addr = 7'd60; start_len = 8'd6; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t6_addr61", 64'(uop_addr), 64'd61);
    reset = 1'b1; start = 1'b1; start_addr = 7'd99; start_len = 8'd3;
    tick();
    chk("t6_rst_addr", 64'(uop_addr), 64'd0);
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_done", 64'(done), 64'd0);
    chk("t6_rst_pc", 64'(out_pc), 64'd0);
    chk("t6_rst_insn", {instruction_2, instruction_1}, 64'd0);
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_dropped", 64'(out_valid), 64'd0);
      chk("t6_still_idle", 64'(busy), 64'd0);
    end
    exp_q.push_back(7'd10);
    exp_q.push_back(7'd11);
    start_addr = 7'd10; start_len = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(10);
    tick();
    chk("t6_idle", 64'(busy), 64'd0);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uop_sequencer.md
Name: uop_sequencer

Overview:
- Drives the read port of the microcode uop buffer (`uop_addr` → `uop`, synchronous read, 1-cycle latency).
- Steps through a bounded run of uops from a start address, splits each 64-bit uop into two 32-bit instructions, and presents them downstream on a valid/ready handshake.
- Handles backpressure with an internal queue and redirect/flush from the pipeline.
- Sits between the uop buffer and the fetch/decode consumer, replacing the current free-running address generation.

Parameters:
- UOP_BUF_SIZE, 128, uop buffer entries; power of two. AW = $clog2(UOP_BUF_SIZE).
- UOP_BUF_WIDTH, 64, uop width; fixed at 64.
- RESET_ADDR, 0, reset value of `uop_addr`.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a run; ignored unless idle
- start_addr  in  AW  first uop address of the run
- start_len  in  AW+1  number of uops in the run (0..UOP_BUF_SIZE)
- redirect  in  1  flush everything and restart at redirect_addr
- redirect_addr  in  AW  new address after a flush
- redirect_len  in  AW+1  new remaining count after a flush
- uop_addr  out  AW  read address to the uop buffer
- uop  in  UOP_BUF_WIDTH  read data; valid one cycle after its address
- out_valid  out  1  instruction pair available
- out_ready  in  1  consumer accepts the pair (not stalled)
- instruction_1  out  32  uop[31:0] of the head entry
- instruction_2  out  32  uop[63:32] of the head entry
- out_pc  out  AW  address the head entry was read from
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when the last uop of the run is accepted

Behaviour:
- States:
  - IDLE → RUN on `start`.
  - RUN → IDLE when remaining == 0, no reads in flight, and the queue is empty after this cycle's pop. `done` pulses on that transition.
- Reset values: `uop_addr` = RESET_ADDR; `out_valid`, `busy`, `done` = 0; `instruction_1`/`instruction_2`/`out_pc` = 0; queue empty; in-flight = 0; remaining = 0.
- Issue: `uop_addr` is a register. A read issues on an edge when:
  - state is RUN, remaining > 0, and
  - (occupancy − pop) + in-flight < UOP_Q_DEPTH.
- On issue:
  - `uop_addr` ← next address.
  - next address ← +1, modulo UOP_BUF_SIZE (wraps 127 → 0).
  - remaining ← remaining − 1.
  - When not issuing, `uop_addr` holds.
- In-flight tracking:
  - A 2-stage valid/address shift tracks issued reads.
  - The entry whose data is on `uop` this cycle is written into the queue at the next edge together with its `out_pc`.
- Latency: `start` sampled at edge 0 → `uop_addr` = start_addr after edge 0 → `uop` data after edge 1 → `out_valid` after edge 2.
  - Throughput is one pair per cycle while `out_ready` = 1.
- Handshake:
  - A pop occurs iff `out_valid` && `out_ready`.
  - Outputs are stable while `out_valid` && !`out_ready`.
  - Push and pop in the same cycle are legal.
  - The queue never overflows; the credit rule above guarantees this.
- Redirect (any state):
  - At the edge, queue and in-flight entries are discarded.
  - `out_valid` = 0 next cycle; a pop in the redirect cycle still counts as accepted.
  - State ← RUN, next address ← redirect_addr, remaining ← redirect_len.
  - No `done` pulse.
- start_len = 0: goes to RUN and returns to IDLE the next edge with a `done` pulse; no reads issued.
- Priority: reset > redirect > start. `start` while busy is ignored.
- Reset mid-run: all state cleared at that edge; data arriving afterwards is dropped.

Decomposition:
- Shared package `uop_pkg`:
  - UOP_Q_DEPTH = 4.
  - Field positions INSN1_LSB = 0, INSN2_LSB = 32.
  - Sequencer state enum {SEQ_IDLE, SEQ_RUN}.
- Sub-module `uop_queue`:
  - UOP_Q_DEPTH-entry synchronous FIFO of {pc, uop}.
  - Ports: push, pop, flush, count, head outputs.

Test Plan:
- start_addr = 5, start_len = 4, out_ready = 1 → out_pc 5, 6, 7, 8 on consecutive cycles, first `out_valid` 3 cycles after `start`; `done` pulses with pc 8; `busy` falls next cycle.
- start_addr = 126, len = 4 → `uop_addr` sequence 126, 127, 0, 1; out_pc matches; instruction fields equal the low and high halves of the memory model words.
- len = 10, out_ready held low 6 cycles after first valid → occupancy stops at 4 and no address advances beyond; head pc 0 held stable; after release, all 10 uops delivered in order with no loss or duplication.
- Redirect to addr 40, len 2 while 3 entries are queued → next `out_valid` shows pc 40, then 41; old entries never appear; `done` pulses once after 41.
- start_len = 0 → `done` pulse 1 cycle later, no `out_valid`, `uop_addr` unchanged.
- Reset asserted mid-run with `start` also high → all outputs return to reset values; `start` ignored that cycle; a new `start` afterwards runs normally.
